rat_recovery_ctrl: RTL and testbench
====================================

// Module: rat_recovery_ctrl
// PURPOSE
//  Sequences speculative-RAT recovery after a redirect/flush. Drives rob_state (IDLE/ROLLBACK/WALK) to the spec RAT.
//  During ROLLBACK the spec RAT copies the arch RAT. During WALK this block reads surviving ROB entries,
//  oldest first, two per cycle, and replays them onto the spec RAT via walking_valid0/1 and rob_walk*_lrd/prd.
//  Sits between the ROB storage, rename and commit. Stalls rename and blocks commit until recovery ends.
// PARAMETERS
//  ROB_DEPTH   64  ROB entries; power of two
//  ROB_IDX_W   6   log2(ROB_DEPTH); ROB pointers carry an extra wrap bit, so they are ROB_IDX_W+1 wide
// PORTS
//  clock             in   1            core clock
//  reset_n           in   1            synchronous, active-low reset
//  flush_valid       in   1            recovery request; single-cycle pulse
//  flush_robidx      in   ROB_IDX_W+1  first squashed entry (exclusive walk end), with wrap bit
//  rob_head          in   ROB_IDX_W+1  oldest uncommitted entry (walk start), with wrap bit
//  walk_rd_addr0     out  ROB_IDX_W    ROB async read address, slot 0 (older)
//  walk_rd_addr1     out  ROB_IDX_W    ROB async read address, slot 1 = addr0+1 mod ROB_DEPTH
//  walk_rd_data0     in   12           {need_to_wb[11], lrd[10:6], prd[5:0]}; same-cycle read data
//  walk_rd_data1     in   12           same layout, slot 1
//  rob_state         out  2            IDLE=2'b00, ROLLBACK=2'b01, WALK=2'b10 (matches `ROB_STATE_*); registered
//  walking_valid0/1  out  1            walk slot carries a valid mapping update
//  rob_walk0/1_lrd   out  5            logical dest of walk slot
//  rob_walk0/1_prd   out  6            physical dest of walk slot
//  rename_stall      out  1            block rename this cycle
//  commit_block      out  1            block commit this cycle (arch RAT frozen)
//  walk_done         out  1            one-cycle pulse; recovery finishes this cycle
// BEHAVIOUR
//  - Reset (reset_n low at posedge):
//    - state=IDLE; walk_ptr=0; walk_end=0.
//    - All outputs are 0, including walking_valid*, stall/block and walk_done.
//  - IDLE:
//    - When flush_valid=1: latch walk_ptr<=rob_head and walk_end<=flush_robidx; next state is ROLLBACK.
//  - ROLLBACK: lasts exactly 1 cycle.
//    - Next state is WALK if remaining!=0, else IDLE.
//    - remaining = walk_end - walk_ptr, computed in ROB_IDX_W+1 bits (modular).
//    - In the IDLE case, walk_done=1 during this ROLLBACK cycle.
//  - Range handling: remaining is valid in 0..ROB_DEPTH.
//    - Full ROB: indices are equal and wrap bits differ, so remaining=ROB_DEPTH.
//    - Empty range: walk_end==walk_ptr, so remaining=0.
//  - WALK, each cycle:
//    - walk_rd_addr0=walk_ptr[ROB_IDX_W-1:0]; walk_rd_addr1=addr0+1, wrapping to 0.
//    - slot0_en = remaining>=1; slot1_en = remaining>=2.
//    - walking_validN = slotN_en & walk_rd_dataN[11]; lrd/prd are taken straight from read data.
//    - walk_ptr advances by slot0_en+slot1_en. This happens regardless of need_to_wb; the wrap bit toggles on overflow.
//    - When remaining<=2: walk_done=1 this cycle and next state is IDLE.
//  - The walk outputs are combinational from the state regs and ROB read data.
//    - They are valid only while rob_state==WALK; otherwise walking_valid*=0 and walk_rd_addr* hold walk_ptr.
//  - Slot 1 is younger. The spec RAT gives slot1 priority on equal lrd; this block does no lrd compare.
//  - rename_stall = (state!=IDLE) | flush_valid.
//  - commit_block = (state!=IDLE) | flush_valid.
//  - Re-flush: flush_valid in ROLLBACK or WALK re-latches walk_ptr<=rob_head and walk_end<=flush_robidx.
//    - Next state is ROLLBACK; the current walk is abandoned.
//    - walk_done is suppressed that cycle; flush has priority over completion.
//  - rob_head is stable while commit_block=1, because commit is blocked.
//  - Reset mid-walk: state returns to IDLE on the next edge; no further walking_valid.
// TESTING
//  1 Reset:
//    reset_n=0 for 2 clk -> rob_state=0, walking_valid*=0, rename_stall=0, commit_block=0, walk_done=0.
//  2 Basic walk, rob_head=3, flush_robidx=8, all need_to_wb=1:
//    -> ROLLBACK 1 cycle.
//    -> WALK cycle 1: addr(3,4), both valid.
//    -> WALK cycle 2: addr(5,6), both valid.
//    -> WALK cycle 3: addr(7,8), valid1=0, walk_done=1.
//    -> IDLE; 5 cycles total of stall.
//  3 Wrap, rob_head=7'b0_111110 (62), flush_robidx=7'b1_000001:
//    -> WALK addr(62,63), then (0,1) with valid1=0 and walk_done.
//    -> walk_ptr ends at 7'b1_000001.
//  4 Empty range and gating:
//    - flush_robidx==rob_head -> ROLLBACK with walk_done=1, then IDLE, no WALK.
//    - need_to_wb=0 on slot1 -> walking_valid1=0, ptr still +2.
//  5 Re-flush: during WALK cycle 2 of test 2, flush_valid with rob_head=3, flush_robidx=5:
//    -> ROLLBACK next cycle.
//    -> WALK addr(3,4) with walk_done=1.
//    -> No entry >=5 is replayed.
//  6 Mid-walk reset: reset_n=0 during WALK -> next cycle rob_state=IDLE, walking_valid*=0, stall deasserted.

Source files
------------

// File: rtl/rat_recovery_ctrl.sv
// Speculative-RAT recovery sequencer: one ROLLBACK cycle (spec RAT <- arch RAT), then a
// two-per-cycle oldest-first replay of surviving ROB entries onto the spec RAT.
module rat_recovery_ctrl #(
    parameter int ROB_DEPTH = 64,
    parameter int ROB_IDX_W = 6
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush_valid,
    input  logic [ROB_IDX_W:0]   flush_robidx,
    input  logic [ROB_IDX_W:0]   rob_head,
    output logic [ROB_IDX_W-1:0] walk_rd_addr0,
    output logic [ROB_IDX_W-1:0] walk_rd_addr1,
    input  logic [11:0]          walk_rd_data0,
    input  logic [11:0]          walk_rd_data1,
    output logic [1:0]           rob_state,
    output logic                 walking_valid0,
    output logic                 walking_valid1,
    output logic [4:0]           rob_walk0_lrd,
    output logic [5:0]           rob_walk0_prd,
    output logic [4:0]           rob_walk1_lrd,
    output logic [5:0]           rob_walk1_prd,
    output logic                 rename_stall,
    output logic                 commit_block,
    output logic                 walk_done
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ROLLBACK = 2'b01,
        ST_WALK     = 2'b10
    } state_t;

    localparam int                 NUM_SLOTS  = 2;
    localparam logic [ROB_IDX_W:0] FULL_RANGE = (ROB_IDX_W+1)'(ROB_DEPTH);

    state_t               state_reg;
    logic [ROB_IDX_W:0]   walk_ptr_reg;
    logic [ROB_IDX_W:0]   walk_end_reg;

    logic [ROB_IDX_W:0]   raw_remaining;
    logic [ROB_IDX_W:0]   remaining;
    logic                 in_walk;
    logic                 last_walk;
    logic                 range_empty;
    logic [ROB_IDX_W:0]   walk_step;

    logic [NUM_SLOTS-1:0] slot_en;
    logic [ROB_IDX_W-1:0] slot_addr  [NUM_SLOTS];
    logic [11:0]          slot_data  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_valid;
    logic [4:0]           slot_lrd   [NUM_SLOTS];
    logic [5:0]           slot_prd   [NUM_SLOTS];

    // Pointers carry a wrap bit, so the modular difference spans 0..ROB_DEPTH;
    // anything larger can only come from malformed pointers and is clamped.
    assign raw_remaining = walk_end_reg - walk_ptr_reg;
    assign remaining     = (raw_remaining > FULL_RANGE) ? FULL_RANGE : raw_remaining;
    assign range_empty   = (remaining == '0);
    assign last_walk     = (remaining <= (ROB_IDX_W+1)'(2));
    assign in_walk       = (state_reg == ST_WALK);

    assign slot_en[0] = in_walk && !range_empty;
    assign slot_en[1] = in_walk && (remaining >= (ROB_IDX_W+1)'(2));

    assign slot_data[0] = walk_rd_data0;
    assign slot_data[1] = walk_rd_data1;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            // Index-only add wraps naturally at ROB_DEPTH (power of two).
            assign slot_addr[gi]  = walk_ptr_reg[ROB_IDX_W-1:0] + ROB_IDX_W'(gi);
            assign slot_valid[gi] = slot_en[gi] & slot_data[gi][11];
            assign slot_lrd[gi]   = slot_data[gi][10:6];
            assign slot_prd[gi]   = slot_data[gi][5:0];
        end
    endgenerate

    assign walk_rd_addr0  = slot_addr[0];
    assign walk_rd_addr1  = slot_addr[1];
    assign walking_valid0 = slot_valid[0];
    assign walking_valid1 = slot_valid[1];
    assign rob_walk0_lrd  = slot_lrd[0];
    assign rob_walk0_prd  = slot_prd[0];
    assign rob_walk1_lrd  = slot_lrd[1];
    assign rob_walk1_prd  = slot_prd[1];

    // Pointer advances over squashed-but-not-writing entries too; need_to_wb only gates the update.
    always_comb begin
        walk_step = '0;
        if (slot_en[1]) begin
            walk_step = (ROB_IDX_W+1)'(2);
        end else if (slot_en[0]) begin
            walk_step = (ROB_IDX_W+1)'(1);
        end
    end

    assign rob_state    = state_reg;
    assign rename_stall = (state_reg != ST_IDLE) | flush_valid;
    assign commit_block = (state_reg != ST_IDLE) | flush_valid;

    // A new flush in the same cycle wins over completion, so done is suppressed.
    always_comb begin
        walk_done = 1'b0;
        if (!flush_valid) begin
            if (state_reg == ST_ROLLBACK && range_empty) begin
                walk_done = 1'b1;
            end else if (in_walk && last_walk) begin
                walk_done = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            walk_ptr_reg <= '0;
            walk_end_reg <= '0;
        end else if (flush_valid) begin
            walk_ptr_reg <= rob_head;
            walk_end_reg <= flush_robidx;
            state_reg    <= ST_ROLLBACK;
        end else begin
            case (state_reg)
                ST_ROLLBACK: begin
                    state_reg <= range_empty ? ST_IDLE : ST_WALK;
                end
                ST_WALK: begin
                    walk_ptr_reg <= walk_ptr_reg + walk_step;
                    if (last_walk) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rat_recovery_ctrl.sv
// Directed bench for rat_recovery_ctrl; a small ROB array answers the async walk reads.
module tb_rat_recovery_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush_valid;
    logic [6:0]  flush_robidx;
    logic [6:0]  rob_head;
    logic [5:0]  walk_rd_addr0;
    logic [5:0]  walk_rd_addr1;
    logic [11:0] walk_rd_data0;
    logic [11:0] walk_rd_data1;
    logic [1:0]  rob_state;
    logic        walking_valid0;
    logic        walking_valid1;
    logic [4:0]  rob_walk0_lrd;
    logic [5:0]  rob_walk0_prd;
    logic [4:0]  rob_walk1_lrd;
    logic [5:0]  rob_walk1_prd;
    logic        rename_stall;
    logic        commit_block;
    logic        walk_done;

    logic [11:0] rob_mem [64];
    int          checks = 0;
    int          passed = 0;

    always #5 clock = ~clock;

    assign walk_rd_data0 = rob_mem[walk_rd_addr0];
    assign walk_rd_data1 = rob_mem[walk_rd_addr1];

    rat_recovery_ctrl #(.ROB_DEPTH(64), .ROB_IDX_W(6)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .flush_valid    (flush_valid),
        .flush_robidx   (flush_robidx),
        .rob_head       (rob_head),
        .walk_rd_addr0  (walk_rd_addr0),
        .walk_rd_addr1  (walk_rd_addr1),
        .walk_rd_data0  (walk_rd_data0),
        .walk_rd_data1  (walk_rd_data1),
        .rob_state      (rob_state),
        .walking_valid0 (walking_valid0),
        .walking_valid1 (walking_valid1),
        .rob_walk0_lrd  (rob_walk0_lrd),
        .rob_walk0_prd  (rob_walk0_prd),
        .rob_walk1_lrd  (rob_walk1_lrd),
        .rob_walk1_prd  (rob_walk1_prd),
        .rename_stall   (rename_stall),
        .commit_block   (commit_block),
        .walk_done      (walk_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_walk(input string tag, input int a0, input int a1,
                              input logic v0, input logic v1, input logic done);
        $display("[%0t] %s: state=%0d addr=(%0d,%0d) valid=(%0b,%0b) done=%0b",
                 $time, tag, rob_state, walk_rd_addr0, walk_rd_addr1,
                 walking_valid0, walking_valid1, walk_done);
        check({tag, ".state"}, 32'(rob_state), 32'd2);
        check({tag, ".addr0"}, 32'(walk_rd_addr0), 32'(a0));
        check({tag, ".addr1"}, 32'(walk_rd_addr1), 32'(a1));
        check({tag, ".valid0"}, 32'(walking_valid0), 32'(v0));
        check({tag, ".valid1"}, 32'(walking_valid1), 32'(v1));
        check({tag, ".done"}, 32'(walk_done), 32'(done));
    endtask

    task automatic flush(input logic [6:0] head, input logic [6:0] fidx);
        flush_valid  = 1'b1;
        rob_head     = head;
        flush_robidx = fidx;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rob_mem[i] = {1'b1, 5'(i), 6'(i)};
        end
        rob_mem[21][11] = 1'b0;
        reset_n      = 1'b0;
        flush_valid  = 1'b0;
        rob_head     = '0;
        flush_robidx = '0;

        // 1: reset
        repeat (2) @(posedge clock);
        #1;
        $display("[%0t] reset: state=%0d stall=%0b block=%0b", $time, rob_state, rename_stall, commit_block);
        check("rst.state", 32'(rob_state), 32'd0);
        check("rst.valid0", 32'(walking_valid0), 32'd0);
        check("rst.valid1", 32'(walking_valid1), 32'd0);
        check("rst.stall", 32'(rename_stall), 32'd0);
        check("rst.block", 32'(commit_block), 32'd0);
        check("rst.done", 32'(walk_done), 32'd0);
        reset_n = 1'b1;
        tick();

        // 2: basic walk 3..7
        flush(7'd3, 7'd8);
        check("t2.flush_stall", 32'(rename_stall), 32'd1);
        check("t2.flush_block", 32'(commit_block), 32'd1);
        tick();
        flush_valid = 1'b0;
        #1;
        check("t2.rb_state", 32'(rob_state), 32'd1);
        check("t2.rb_done", 32'(walk_done), 32'd0);
        check("t2.rb_stall", 32'(rename_stall), 32'd1);
        tick();
        check_walk("t2.w1", 3, 4, 1'b1, 1'b1, 1'b0);
        check("t2.w1.lrd0", 32'(rob_walk0_lrd), 32'd3);
        check("t2.w1.prd0", 32'(rob_walk0_prd), 32'd3);
        check("t2.w1.lrd1", 32'(rob_walk1_lrd), 32'd4);
        check("t2.w1.prd1", 32'(rob_walk1_prd), 32'd4);
        tick();
        check_walk("t2.w2", 5, 6, 1'b1, 1'b1, 1'b0);
        tick();
        check_walk("t2.w3", 7, 8, 1'b1, 1'b0, 1'b1);
        check("t2.w3.stall", 32'(rename_stall), 32'd1);
        tick();
        check("t2.end_state", 32'(rob_state), 32'd0);
        check("t2.end_stall", 32'(rename_stall), 32'd0);
        check("t2.end_valid0", 32'(walking_valid0), 32'd0);

        // 3: wrap 62 -> 1_000001
        flush(7'b0_111110, 7'b1_000001);
        tick();
        flush_valid = 1'b0;
        #1;
        check("t3.rb_state", 32'(rob_state), 32'd1);
        tick();
        check_walk("t3.w1", 62, 63, 1'b1, 1'b1, 1'b0);
        tick();
        check_walk("t3.w2", 0, 1, 1'b1, 1'b0, 1'b1);
        tick();
        check("t3.end_state", 32'(rob_state), 32'd0);
        check("t3.end_ptr", 32'(walk_rd_addr0), 32'd1);

        // 4a: empty range
        flush(7'd10, 7'd10);
        tick();
        flush_valid = 1'b0;
        #1;
        check("t4.rb_state", 32'(rob_state), 32'd1);
        check("t4.rb_done", 32'(walk_done), 32'd1);
        tick();
        check("t4.end_state", 32'(rob_state), 32'd0);
        check("t4.end_done", 32'(walk_done), 32'd0);

        // 4b: entry 21 has need_to_wb=0
        flush(7'd20, 7'd24);
        tick();
        flush_valid = 1'b0;
        tick();
        check_walk("t4.w1", 20, 21, 1'b1, 1'b0, 1'b0);
        tick();
        check_walk("t4.w2", 22, 23, 1'b1, 1'b1, 1'b1);
        tick();
        check("t4.end_state", 32'(rob_state), 32'd0);

        // full ROB: 0 -> 1_000000, 32 walk cycles
        flush(7'd0, 7'b1_000000);
        tick();
        flush_valid = 1'b0;
        #1;
        check("full.rb_state", 32'(rob_state), 32'd1);
        check("full.rb_done", 32'(walk_done), 32'd0);
        for (int i = 0; i < 32; i++) begin
            tick();
            check("full.addr0", 32'(walk_rd_addr0), 32'(2 * i));
            check("full.addr1", 32'(walk_rd_addr1), 32'(2 * i + 1));
            check("full.done", 32'(walk_done), (i == 31) ? 32'd1 : 32'd0);
        end
        tick();
        check("full.end_state", 32'(rob_state), 32'd0);
        check("full.end_ptr", 32'(walk_rd_addr0), 32'd0);

        // 5: re-flush during WALK cycle 2
        flush(7'd3, 7'd8);
        tick();
        flush_valid = 1'b0;
        tick();
        check_walk("t5.w1", 3, 4, 1'b1, 1'b1, 1'b0);
        tick();
        check_walk("t5.w2", 5, 6, 1'b1, 1'b1, 1'b0);
        flush(7'd3, 7'd5);
        tick();
        flush_valid = 1'b0;
        #1;
        check("t5.rb_state", 32'(rob_state), 32'd1);
        tick();
        check_walk("t5.rw", 3, 4, 1'b1, 1'b1, 1'b1);
        tick();
        check("t5.end_state", 32'(rob_state), 32'd0);
        check("t5.end_valid0", 32'(walking_valid0), 32'd0);

        // 5b: re-flush on the final walk cycle suppresses walk_done
        flush(7'd3, 7'd5);
        tick();
        flush_valid = 1'b0;
        tick();
        flush(7'd3, 7'd5);
        check("t5b.suppress_done", 32'(walk_done), 32'd0);
        check("t5b.state", 32'(rob_state), 32'd2);
        tick();
        flush_valid = 1'b0;
        #1;
        check("t5b.rb_state", 32'(rob_state), 32'd1);
        tick();
        check_walk("t5b.rw", 3, 4, 1'b1, 1'b1, 1'b1);
        tick();

        // 6: reset mid-walk
        flush(7'd3, 7'd8);
        tick();
        flush_valid = 1'b0;
        tick();
        check_walk("t6.w1", 3, 4, 1'b1, 1'b1, 1'b0);
        reset_n = 1'b0;
        tick();
        check("t6.state", 32'(rob_state), 32'd0);
        check("t6.valid0", 32'(walking_valid0), 32'd0);
        check("t6.valid1", 32'(walking_valid1), 32'd0);
        check("t6.stall", 32'(rename_stall), 32'd0);
        check("t6.block", 32'(commit_block), 32'd0);
        reset_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
